ccu_cmd_tx: RTL

Command-stream transmitter that feeds the CCU's 8-bit `cmd` byte input. It accepts a single draw request (point or line, with coordinates and colour) on a valid/ready handshake and serializes it into the CCU opcode and argument byte sequence, one byte per `clk` cycle. Because the CCU has no ready or busy output, the block then holds `cmd` at NOP for a computed number of cycles while the CCU runs its line loop. It sits between the host or scene logic and the CCU.

---
 rtl/ccu_cmd_pkg.sv | 19 +
 rtl/ccu_holdoff_counter.sv | 25 ++
 rtl/ccu_cmd_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ccu_cmd_pkg.sv
// Shared definitions for the CCU command byte stream and its transmitter.
package ccu_cmd_pkg;

  localparam logic [7:0] CMD_POINT = 8'h50;
  localparam logic [7:0] CMD_LINE  = 8'h4C;
  localparam logic [7:0] CMD_NOP   = 8'h00;

  localparam int unsigned LINE_SETUP_CYCLES = 7;
  localparam int unsigned LINE_ITER_CYCLES  = 5;
  localparam int unsigned HOLD_W            = 11;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_ARG,
    TX_HOLD
  } tx_state_t;

endpackage

// File: rtl/ccu_holdoff_counter.sv
// Loadable down-counter timing the NOP hold-off after a line command.
module ccu_holdoff_counter
  import ccu_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [HOLD_W-1:0] din,
  output logic [HOLD_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= din;
    else if (en && (count != '0))
      count <= count - 11'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ccu_cmd_tx.sv
// Serializes point/line draw requests into CCU command bytes, then holds NOP
// long enough for the CCU line loop to finish (the CCU has no busy output).
module ccu_cmd_tx
  import ccu_cmd_pkg::*;
#(
  parameter int unsigned GUARD     = 2,
  parameter bit          NORMALIZE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_x0,
  input  logic [7:0] req_y0,
  input  logic [7:0] req_x1,
  input  logic [7:0] req_y1,
  input  logic [7:0] req_colour,
  output logic [7:0] cmd,
  output logic       busy,
  output logic       done
);

  tx_state_t         state;
  logic              op_q;
  logic [7:0]        x0_q, y0_q, x1_q, y1_q, col_q;
  logic [2:0]        idx;
  logic [2:0]        last_idx;
  logic [2:0]        arg_sel;
  logic [7:0]        arg_byte;
  logic [8:0]        span;
  logic [HOLD_W-1:0] hold_len;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_zero;
  logic              hold_load;
  logic              hold_exit;
  logic              accept;
  logic              swap;

  assign req_ready = (state == TX_IDLE);
  assign busy      = (state != TX_IDLE);
  assign accept    = req_valid && req_ready;
  assign swap      = NORMALIZE && req_op && (req_x1 < req_x0);
  assign last_idx  = op_q ? 3'd4 : 3'd2;
  assign arg_sel   = (state == TX_HDR) ? 3'd0 : idx + 3'd1;

  // Point args are x0,y0,colour; line args are x0,y0,x1,y1,colour.
  always_comb begin
    arg_byte = col_q;
    case (arg_sel)
      3'd0:    arg_byte = x0_q;
      3'd1:    arg_byte = y0_q;
      3'd2:    arg_byte = op_q ? x1_q : col_q;
      3'd3:    arg_byte = y1_q;
      default: arg_byte = col_q;
    endcase
  end

  always_comb begin
    span     = (x1_q >= x0_q) ? (9'(x1_q) - 9'(x0_q) + 9'd1) : 9'd1;
    hold_len = 11'(LINE_SETUP_CYCLES) + 11'(LINE_ITER_CYCLES) * {2'b00, span}
             + 11'(GUARD);
  end

  assign hold_load = (state == TX_ARG) && (idx == last_idx) && op_q;
  // Leave on the edge that takes the counter to zero so HOLD lasts exactly H cycles.
  assign hold_exit = (hold_cnt == 11'd1) || hold_zero;

  ccu_holdoff_counter u_holdoff (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .en    (state == TX_HOLD),
    .din   (hold_len),
    .count (hold_cnt),
    .zero  (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= TX_IDLE;
      cmd   <= CMD_NOP;
      done  <= 1'b0;
      idx   <= '0;
      op_q  <= 1'b0;
      x0_q  <= '0;
      y0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      col_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          cmd <= CMD_NOP;
          if (accept) begin
            op_q  <= req_op;
            x0_q  <= swap ? req_x1 : req_x0;
            y0_q  <= swap ? req_y1 : req_y0;
            x1_q  <= swap ? req_x0 : req_x1;
            y1_q  <= swap ? req_y0 : req_y1;
            col_q <= req_colour;
            cmd   <= req_op ? CMD_LINE : CMD_POINT;
            state <= TX_HDR;
          end
        end
        TX_HDR: begin
          cmd   <= arg_byte;
          idx   <= '0;
          state <= TX_ARG;
        end
        TX_ARG: begin
          if (idx == last_idx) begin
            cmd <= CMD_NOP;
            if (op_q) begin
              state <= TX_HOLD;
            end else begin
              state <= TX_IDLE;
              done  <= 1'b1;
            end
          end else begin
            cmd <= arg_byte;
            idx <= idx + 3'd1;
          end
        end
        TX_HOLD: begin
          cmd <= CMD_NOP;
          if (hold_exit) begin
            state <= TX_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
